reg_file_cf: RTL and testbench

Operand and writeback stage for the HC4e datapath: a 16 × 4-bit register file plus carry flag that sits around the ALU. Two asynchronous read ports drive the ALU `in_A`/`in_B` operands and the carry flag drives `carry_in`. ALU `out`/`carry_out` are written back through a one-entry pending-write register, so back-to-back ALU operations sustain one writeback per clock.

---
 rtl/hc4e_pkg.sv | 17 +
 rtl/reg_file_cf_if.sv | 35 +++
 rtl/rf_read_port.sv | 45 ++++
 rtl/reg_file_cf.sv | 92 +++++++++
 tb/tb_reg_file_cf.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/hc4e_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hc4e_pkg
//  Brief    : Shared HC4e datapath widths and types.
//  Revision : 1.0
// ============================================================================
package hc4e_pkg;

  localparam int WORD_W = 4;
  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_AW-1:0] regaddr_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_cf_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_cf_if
//  Brief    : Operand-read and writeback bus between sequencer/ALU and reg_file_cf.
//  Revision : 1.0
// ============================================================================
interface reg_file_cf_if #(
  parameter int AW = hc4e_pkg::REG_AW,
  parameter int W  = hc4e_pkg::WORD_W
);

  logic [AW-1:0] ra_addr;
  logic [AW-1:0] rb_addr;
  logic [W-1:0]  ra_data;
  logic [W-1:0]  rb_data;
  logic          cf;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          wb_carry;
  logic          wb_cf_we;
  logic          hazard;

  modport master (
    output ra_addr, rb_addr, wb_valid, wb_addr, wb_data, wb_carry, wb_cf_we,
    input  ra_data, rb_data, cf, hazard
  );

  modport slave (
    input  ra_addr, rb_addr, wb_valid, wb_addr, wb_data, wb_carry, wb_cf_we,
    output ra_data, rb_data, cf, hazard
  );

endinterface
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : rf_read_port
//  Brief    : One combinational register-file read port; REG_BYPASS_EN selects
//             pending-entry forwarding instead of a stall request.
//  Revision : 1.0
// ============================================================================
module rf_read_port
  import hc4e_pkg::*;
#(
  parameter int NREGS = hc4e_pkg::NREGS,
  parameter int W     = hc4e_pkg::WORD_W,
  parameter int AW    = hc4e_pkg::REG_AW
) (
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  regs [NREGS],
  input  logic          pend_valid,
  input  logic [AW-1:0] pend_addr,
  input  logic [W-1:0]  pend_data,
  output logic [W-1:0]  data,
  output logic          hazard
);

  localparam logic [AW:0] c_nregs = (AW+1)'(NREGS);

  logic          w_in_range;
  logic          w_hit;
  logic [W-1:0]  w_array_data;

  assign w_in_range   = ({1'b0, addr} < c_nregs);
  assign w_hit        = pend_valid && (addr == pend_addr);
  assign w_array_data = w_in_range ? regs[addr] : '0;

`ifdef REG_BYPASS_EN
  assign data   = w_hit ? pend_data : w_array_data;
  assign hazard = 1'b0;
`else
  logic w_unused_pend;
  assign w_unused_pend = ^pend_data;
  assign data          = w_array_data;
  assign hazard        = w_hit;
`endif

endmodule
`default_nettype wire

// File: rtl/reg_file_cf.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_cf
//  Brief    : HC4e register file + carry flag with a one-entry pending
//             writeback register. Macro REG_BYPASS_EN enables read bypass.
//  Revision : 1.0
// ============================================================================
module reg_file_cf
  import hc4e_pkg::*;
#(
  parameter  int NREGS = hc4e_pkg::NREGS,
  parameter  int W     = hc4e_pkg::WORD_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_cf_if.slave  bus
);

  localparam logic [AW:0] c_nregs = (AW+1)'(NREGS);

  logic [W-1:0]  r_regs [NREGS];
  logic          r_cf;
  logic          r_pend_valid;
  logic [AW-1:0] r_pend_addr;
  logic [W-1:0]  r_pend_data;

  logic          w_wb_in_range;
  logic          w_hazard_a;
  logic          w_hazard_b;

  assign w_wb_in_range = ({1'b0, bus.wb_addr} < c_nregs);

  // Out-of-range writes never become pending, so they can neither commit,
  // forward, nor raise a hazard; the carry flag still updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_cf         <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
    end else begin
      if (r_pend_valid) begin
        r_regs[r_pend_addr] <= r_pend_data;
      end
      r_pend_valid <= bus.wb_valid && w_wb_in_range;
      if (bus.wb_valid) begin
        r_pend_addr <= bus.wb_addr;
        r_pend_data <= bus.wb_data;
        if (bus.wb_cf_we) begin
          r_cf <= bus.wb_carry;
        end
      end
    end
  end

  rf_read_port #(
    .NREGS (NREGS),
    .W     (W),
    .AW    (AW)
  ) u_port_a (
    .addr       (bus.ra_addr),
    .regs       (r_regs),
    .pend_valid (r_pend_valid),
    .pend_addr  (r_pend_addr),
    .pend_data  (r_pend_data),
    .data       (bus.ra_data),
    .hazard     (w_hazard_a)
  );

  rf_read_port #(
    .NREGS (NREGS),
    .W     (W),
    .AW    (AW)
  ) u_port_b (
    .addr       (bus.rb_addr),
    .regs       (r_regs),
    .pend_valid (r_pend_valid),
    .pend_addr  (r_pend_addr),
    .pend_data  (r_pend_data),
    .data       (bus.rb_data),
    .hazard     (w_hazard_b)
  );

  assign bus.cf     = r_cf;
  assign bus.hazard = w_hazard_a | w_hazard_b;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_cf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_cf
//  Brief    : Self-checking bench for reg_file_cf (NREGS=16 and NREGS=12).
//  Revision : 1.0
// ============================================================================
module tb_reg_file_cf;

`ifdef REG_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_cf_if #(.AW(4), .W(4)) bus16 ();
  reg_file_cf_if #(.AW(4), .W(4)) bus12 ();

  reg_file_cf #(.NREGS(16), .W(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  reg_file_cf #(.NREGS(12), .W(4)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic wv, input logic [3:0] wa, input logic [3:0] wd,
                         input logic wc, input logic wce,
                         input logic [3:0] ra, input logic [3:0] rb);
    bus16.wb_valid = wv;
    bus16.wb_addr  = wa;
    bus16.wb_data  = wd;
    bus16.wb_carry = wc;
    bus16.wb_cf_we = wce;
    bus16.ra_addr  = ra;
    bus16.rb_addr  = rb;
  endtask

  task automatic drive12(input logic wv, input logic [3:0] wa, input logic [3:0] wd,
                         input logic wc, input logic wce,
                         input logic [3:0] ra, input logic [3:0] rb);
    bus12.wb_valid = wv;
    bus12.wb_addr  = wa;
    bus12.wb_data  = wd;
    bus12.wb_carry = wc;
    bus12.wb_cf_we = wce;
    bus12.ra_addr  = ra;
    bus12.rb_addr  = rb;
  endtask

  typedef struct {
    logic       wv;
    logic [3:0] wa;
    logic [3:0] wd;
    logic       wc;
    logic       wce;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] era;
    logic [3:0] erb;
    logic       ecf;
    logic       ehz;
  } vec_t;

  vec_t tbl [16];

  // Reference model: "latest" holds every captured write immediately; the
  // array view is the latest state as it stood one edge earlier.
  int  m_latest [16];
  int  m_array  [16];
  bit  m_cf;
  bit  m_last_v;
  int  m_last_a;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_latest[i] = 0;
      m_array[i]  = 0;
    end
    m_cf     = 1'b0;
    m_last_v = 1'b0;
    m_last_a = 0;
  endtask

  task automatic model_edge(input bit wv, input int wa, input int wd, input bit wc, input bit wce);
    for (int i = 0; i < 16; i++) m_array[i] = m_latest[i];
    if (wv) begin
      m_latest[wa] = wd;
      if (wce) m_cf = wc;
    end
    m_last_v = wv;
    m_last_a = wa;
  endtask

  function automatic int model_read(input int a);
    return BP ? m_latest[a] : m_array[a];
  endfunction

  initial begin
    drive16(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    drive12(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);

    // Vector table: latency, back-to-back, carry and dual-port same address.
    tbl[0]  = '{1'b1, 4'h5, 4'hA, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h5, 4'h5, BP ? 4'hA : 4'h0, BP ? 4'hA : 4'h0, 1'b0, !BP};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h5, 4'h0, 4'hA, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'h1, 4'h3, 1'b0, 1'b0, 4'h1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'h2, 4'hC, 1'b0, 1'b0, 4'h1, 4'h2, BP ? 4'h3 : 4'h0, 4'h0, 1'b0, !BP};
    tbl[5]  = '{1'b1, 4'h1, 4'hF, 1'b0, 1'b0, 4'h1, 4'h2, 4'h3, BP ? 4'hC : 4'h0, 1'b0, !BP};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h2, BP ? 4'hF : 4'h3, 4'hC, 1'b0, !BP};
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h2, 4'hF, 4'hC, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h5, 4'h1, 4'hA, 4'hF, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h5, 4'h1, 4'hA, 4'hF, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 4'h9, 4'h2, 1'b0, 1'b0, 4'h9, 4'h9, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 4'h9, 4'h6, 1'b0, 1'b0, 4'h9, 4'h9, BP ? 4'h2 : 4'h0, BP ? 4'h2 : 4'h0, 1'b1, !BP};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h9, 4'h9, BP ? 4'h6 : 4'h2, BP ? 4'h6 : 4'h2, 1'b1, !BP};
    tbl[15] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h9, 4'h9, 4'h6, 4'h6, 1'b1, 1'b0};

    // Reset state while rst is held.
    #2;
    chk("rst_ra",   int'(bus16.ra_data), 0);
    chk("rst_rb",   int'(bus16.rb_data), 0);
    chk("rst_cf",   int'(bus16.cf), 0);
    chk("rst_hz",   int'(bus16.hazard), 0);
    chk("rst_cf12", int'(bus12.cf), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Mid-cycle reset with a pending 0x7 -> R3 and cf set.
    drive16(1'b1, 4'h3, 4'h7, 1'b1, 1'b1, 4'h3, 4'h3);
    tick();
    drive16(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 4'h3);
    #1;
    chk("pre_rst_cf", int'(bus16.cf), 1);
    chk("pre_rst_hz", int'(bus16.hazard), BP ? 0 : 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_cf", int'(bus16.cf), 0);
    chk("midrst_ra", int'(bus16.ra_data), 0);
    chk("midrst_hz", int'(bus16.hazard), 0);
    #2;
    rst = 1'b0;
    tick();
    chk("postrst_r3", int'(bus16.ra_data), 0);
    chk("postrst_hz", int'(bus16.hazard), 0);
    chk("postrst_cf", int'(bus16.cf), 0);
    tick();
    chk("postrst_r3_b", int'(bus16.ra_data), 0);

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      drive16(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].wc, tbl[i].wce, tbl[i].ra, tbl[i].rb);
      #1;
      chk($sformatf("vec%0d_ra", i), int'(bus16.ra_data), int'(tbl[i].era));
      chk($sformatf("vec%0d_rb", i), int'(bus16.rb_data), int'(tbl[i].erb));
      chk($sformatf("vec%0d_cf", i), int'(bus16.cf),      int'(tbl[i].ecf));
      chk($sformatf("vec%0d_hz", i), int'(bus16.hazard),  int'(tbl[i].ehz));
      tick();
    end
    drive16(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);

    // Out-of-range write on the 12-entry instance.
    drive12(1'b1, 4'd11, 4'h5, 1'b0, 1'b0, 4'd11, 4'd11);
    tick();
    drive12(1'b1, 4'd14, 4'h9, 1'b1, 1'b1, 4'd14, 4'd11);
    tick();
    drive12(1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 4'd14, 4'd11);
    #1;
    chk("oor_ra14", int'(bus12.ra_data), 0);
    chk("oor_rb11", int'(bus12.rb_data), 5);
    chk("oor_cf",   int'(bus12.cf), 1);
    chk("oor_hz",   int'(bus12.hazard), 0);
    tick();
    for (int a = 0; a < 16; a++) begin
      bus12.ra_addr = 4'(a);
      #1;
      chk($sformatf("oor_sweep%0d", a), int'(bus12.ra_data), (a == 11) ? 5 : 0);
    end
    chk("oor_cf_b", int'(bus12.cf), 1);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
    tick();
    for (int n = 0; n < 400; n++) begin
      logic       wv, wc, wce;
      logic [3:0] wa, wd, ra, rb;
      wv  = ($urandom_range(0, 9) < 7);
      wa  = 4'($urandom_range(0, 15));
      wd  = 4'($urandom_range(0, 15));
      wc  = 1'($urandom_range(0, 1));
      wce = 1'($urandom_range(0, 1));
      ra  = (n % 3 == 0) ? 4'(m_last_a) : 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      drive16(wv, wa, wd, wc, wce, ra, rb);
      #1;
      chk("rnd_ra", int'(bus16.ra_data), model_read(int'(ra)));
      chk("rnd_rb", int'(bus16.rb_data), model_read(int'(rb)));
      chk("rnd_cf", int'(bus16.cf), int'(m_cf));
      chk("rnd_hz", int'(bus16.hazard),
          (!BP && m_last_v && (int'(ra) == m_last_a || int'(rb) == m_last_a)) ? 1 : 0);
      tick();
      model_edge(wv, int'(wa), int'(wd), wc, wce);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
